// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Two-stage valid/ready pipelined bitwise logic unit with a
//            completed-transaction counter. Optional zero/parity flags are
//            enabled by defining LU_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LU_FLAGS_EN
    output logic             zero,
    output logic             parity,
`endif
    output logic [CNT_W-1:0] tx_cnt
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_NAND = 3'b001;
    localparam logic [2:0] c_OP_NOR  = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_XNOR = 3'b100;
    localparam logic [2:0] c_OP_NOT  = 3'b101;
    localparam logic [2:0] c_OP_OR   = 3'b110;

    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s1_v;
    logic [WIDTH-1:0] r_y;
    logic             r_s2_v;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_res;

    // A stage may advance when it is empty or when its successor advances.
    assign w_s2_adv = !r_s2_v | out_ready;
    assign w_s1_adv = !r_s1_v | w_s2_adv;

    always_comb begin
        w_res = r_s1_a;
        case (r_s1_op)
            c_OP_AND:  w_res = r_s1_a & r_s1_b;
            c_OP_NAND: w_res = ~(r_s1_a & r_s1_b);
            c_OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
            c_OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            c_OP_XNOR: w_res = ~(r_s1_a ^ r_s1_b);
            c_OP_NOT:  w_res = ~r_s1_a;
            c_OP_OR:   w_res = r_s1_a | r_s1_b;
            default:   w_res = r_s1_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_op <= '0;
            r_s1_v  <= 1'b0;
            r_y     <= '0;
            r_s2_v  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_s1_a  <= a;
                    r_s1_b  <= b;
                    r_s1_op <= op;
                end
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_y <= w_res;
                end
            end
            if (r_s2_v && out_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef LU_FLAGS_EN
    logic r_zero;
    logic r_parity;

    // Flags travel with y so they share its latency and stall behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero   <= 1'b1;
            r_parity <= 1'b0;
        end else if (w_s2_adv && r_s1_v) begin
            r_zero   <= (w_res == '0);
            r_parity <= ^w_res;
        end
    end

    assign zero   = r_zero;
    assign parity = r_parity;
`endif

    assign in_ready  = w_s1_adv;
    assign y         = r_y;
    assign out_valid = r_s2_v;
    assign tx_cnt    = r_cnt;

endmodule
`default_nettype wire
